// File: rtl/pcap_dma_pkg.sv
// pcap_dma_pkg: types and constants shared by the pcap DMA engine and its FIFO.
//   dma_state_e   : engine FSM states
//   IRQ_*         : bit positions inside IRQ_STATUS
//   BEAT_BYTES    : byte stride of one 32-bit memory beat
package pcap_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    CLOSE = 2'd3
  } dma_state_e;

  localparam int IRQ_BLOCK_FULL = 0;
  localparam int IRQ_DONE       = 1;
  localparam int IRQ_OVERFLOW   = 2;
  localparam int IRQ_STALL      = 3;
  localparam int IRQ_TIMEOUT    = 4;

  localparam logic [31:0] BEAT_BYTES = 32'd4;

endpackage

// File: rtl/pcap_dma_fifo.sv
// pcap_dma_fifo: synchronous first-word-fall-through FIFO, 32-bit words.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : synchronous clear (pointers and count)
//   push_i, dat_i  : write request and word; ignored while full
//   pop_i          : remove head word; ignored while empty
//   head_o         : current head word, valid whenever count_o != 0
//   count_o        : words held (0 .. 2**AW)
//   full_o         : count_o == 2**AW
module pcap_dma_fifo #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [31:0]   dat_i,
  input  logic          pop_i,
  output logic [31:0]   head_o,
  output logic [AW:0]   count_o,
  output logic          full_o
);
  import pcap_dma_pkg::*;

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_o == DEPTH_C);
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & (count_o != '0) & ~clear_i;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/pcap_dma_engine.sv
// pcap_dma_engine: buffers pcap_core capture words and writes them to host
// memory in bursts of up to BURST_LEN beats into host-supplied buffers.
//   clk_i, reset_i         : clock, asynchronous active-high reset
//   pcap_dat_i/_valid_i    : capture word stream in
//   pcap_done_i            : end-of-capture pulse
//   dma_fifo_reset_i       : synchronous clear of FIFO and engine
//   DMA_ADDR/_WSTB         : one-deep next-buffer address queue
//   BLOCK_SIZE             : buffer length in bytes
//   TIMEOUT                : idle-flush timeout, used only with PCAP_DMA_TIMEOUT_EN
//   dma_full_o             : FIFO almost full back-pressure
//   mem_*                  : beat-level memory write interface
//   irq_o, IRQ_STATUS, SAMPLES : per-buffer interrupt and its status
// Optional feature macro: PCAP_DMA_TIMEOUT_EN (idle-flush of partial bursts).
//
// state | meaning
// IDLE  | no buffer open; wait for a queued address
// WAIT  | buffer open; wait for a full burst, a done flush or a timeout
// BURST | moving beats from FIFO head to memory
// CLOSE | buffer finished; raise irq, open next queued buffer if any
module pcap_dma_engine #(
  parameter int FIFO_AW     = 8,
  parameter int BURST_LEN   = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pcap_dat_i,
  input  logic        pcap_dat_valid_i,
  input  logic        pcap_done_i,
  input  logic        dma_fifo_reset_i,
  input  logic [31:0] DMA_ADDR,
  input  logic        DMA_ADDR_WSTB,
  input  logic [31:0] BLOCK_SIZE,
  input  logic [31:0] TIMEOUT,
  output logic        dma_full_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dat_o,
  output logic        mem_valid_o,
  output logic        mem_last_o,
  input  logic        mem_ready_i,
  output logic        irq_o,
  output logic [31:0] IRQ_STATUS,
  output logic [31:0] SAMPLES
);
  import pcap_dma_pkg::*;

  localparam int CW = FIFO_AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BURST_C  = CW'(BURST_LEN);
  localparam logic [CW-1:0] FULL_THR = CW'(2**FIFO_AW - FULL_MARGIN);
  localparam logic [CW-1:0] ONE_WORD = CW'(1);
  localparam logic [BW-1:0] ONE_BEAT = BW'(1);

  dma_state_e    state;
  logic [31:0]   base;
  logic [31:0]   offset;
  logic [31:0]   offset_nx;
  logic [BW-1:0] beats_left;
  logic [31:0]   addr_q;
  logic          addr_q_vld;
  logic          done_pend;
  logic          overflow;
  logic          stall;
  logic          tmo_flag;
  logic          tmo_hit;
  logic [31:0]   status_nx;

  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          pop;
  logic          fifo_drained;

  logic          unused_bits;
  assign unused_bits = ^DMA_ADDR[1:0];

  pcap_dma_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (dma_fifo_reset_i),
    .push_i  (pcap_dat_valid_i),
    .dat_i   (pcap_dat_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  assign mem_valid_o = (state == BURST);
  assign mem_last_o  = mem_valid_o && (beats_left == ONE_BEAT);
  assign mem_addr_o  = mem_valid_o ? (base + offset) : '0;
  assign mem_dat_o   = mem_valid_o ? fifo_head : '0;
  assign pop         = mem_valid_o & mem_ready_i;
  assign offset_nx   = offset + BEAT_BYTES;
  // Head word is the last one and nothing is arriving this cycle.
  assign fifo_drained = (fifo_count == ONE_WORD) && !pcap_dat_valid_i;

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_arm;

  assign tmo_arm = (state == WAIT) && (fifo_count != '0) && (fifo_count < BURST_C)
                   && !pcap_dat_valid_i && (TIMEOUT != '0);
  assign tmo_hit = tmo_arm && (tmo_cnt == 32'd1);

  // Down-counter reloaded by any push or whenever the partial-data condition breaks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                          tmo_cnt <= '0;
    else if (dma_fifo_reset_i || !tmo_arm) tmo_cnt <= TIMEOUT;
    else if (tmo_cnt != '0)               tmo_cnt <= tmo_cnt - 32'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    status_nx = '0;
    status_nx[IRQ_BLOCK_FULL] = (offset == BLOCK_SIZE);
    status_nx[IRQ_DONE]       = done_pend;
    status_nx[IRQ_OVERFLOW]   = overflow;
    status_nx[IRQ_STALL]      = stall;
    status_nx[IRQ_TIMEOUT]    = tmo_flag;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      base       <= '0;
      offset     <= '0;
      beats_left <= '0;
      addr_q     <= '0;
      addr_q_vld <= 1'b0;
      done_pend  <= 1'b0;
      overflow   <= 1'b0;
      stall      <= 1'b0;
      tmo_flag   <= 1'b0;
      dma_full_o <= 1'b0;
      irq_o      <= 1'b0;
      IRQ_STATUS <= '0;
      SAMPLES    <= '0;
    end else if (dma_fifo_reset_i) begin
      state      <= IDLE;
      base       <= '0;
      offset     <= '0;
      beats_left <= '0;
      addr_q     <= '0;
      addr_q_vld <= 1'b0;
      done_pend  <= 1'b0;
      overflow   <= 1'b0;
      stall      <= 1'b0;
      tmo_flag   <= 1'b0;
      dma_full_o <= 1'b0;
      irq_o      <= 1'b0;
      IRQ_STATUS <= '0;
      SAMPLES    <= '0;
    end else begin
      irq_o      <= 1'b0;
      dma_full_o <= (fifo_count >= FULL_THR);
      if (DMA_ADDR_WSTB) begin
        addr_q     <= {DMA_ADDR[31:2], 2'b00};
        addr_q_vld <= 1'b1;
      end
      if (pcap_dat_valid_i && fifo_full) overflow <= 1'b1;
      if (state == IDLE && !addr_q_vld && pcap_dat_valid_i) stall <= 1'b1;
      if (pcap_done_i) done_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (addr_q_vld) begin
            base   <= addr_q;
            offset <= '0;
            if (!DMA_ADDR_WSTB) addr_q_vld <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (fifo_count >= BURST_C) begin
            beats_left <= BW'(BURST_LEN);
            state      <= BURST;
          end else if (done_pend && fifo_count != '0) begin
            beats_left <= fifo_count[BW-1:0];
            state      <= BURST;
          end else if (done_pend) begin
            state <= CLOSE;
          end else if (tmo_hit) begin
            beats_left <= fifo_count[BW-1:0];
            tmo_flag   <= 1'b1;
            state      <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            offset     <= offset_nx;
            beats_left <= beats_left - ONE_BEAT;
            if (beats_left == ONE_BEAT) begin
              if (offset_nx == BLOCK_SIZE || tmo_flag || (done_pend && fifo_drained))
                state <= CLOSE;
              else
                state <= WAIT;
            end
          end
        end
        CLOSE: begin
          irq_o      <= 1'b1;
          IRQ_STATUS <= status_nx;
          SAMPLES    <= offset >> 2;
          // A done arriving in this very cycle belongs to the next buffer.
          done_pend  <= pcap_done_i;
          tmo_flag   <= 1'b0;
          if (addr_q_vld) begin
            base   <= addr_q;
            offset <= '0;
            if (!DMA_ADDR_WSTB) addr_q_vld <= 1'b0;
            state  <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcap_dma_engine.md
Name: pcap_dma_engine

Overview:
Consumer end of the position-capture data stream: accepts 32-bit capture words and strobes from pcap_core, buffers them in a FIFO, and writes them to host memory in fixed-length bursts into host-supplied buffers. It drives dma_full back to pcap_core. It raises an interrupt per completed buffer and on end of capture.

Parameters:
FIFO_AW, 8, FIFO address width; depth = 2**FIFO_AW words.
BURST_LEN, 16, maximum beats per memory burst; power of two, at most FIFO depth/2.
FULL_MARGIN, 4, words of headroom below depth at which dma_full_o asserts.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
pcap_dat_i  in  32  capture data word from pcap_core
pcap_dat_valid_i  in  1  data strobe; one word per cycle when high
pcap_done_i  in  1  one-cycle pulse at end of capture
dma_fifo_reset_i  in  1  synchronous clear of FIFO and engine, from pcap_core
DMA_ADDR  in  32  next host buffer byte address; bits [1:0] ignored
DMA_ADDR_WSTB  in  1  write strobe for DMA_ADDR
BLOCK_SIZE  in  32  buffer length in bytes; multiple of 4*BURST_LEN
TIMEOUT  in  32  idle-flush timeout in clocks; 0 disables; only with the optional feature
dma_full_o  out  1  FIFO almost full, to pcap_core dma_full_i
mem_addr_o  out  32  byte address of the current beat
mem_dat_o  out  32  beat data
mem_valid_o  out  1  beat valid
mem_last_o  out  1  final beat of the burst
mem_ready_i  in  1  memory side accepts the beat
irq_o  out  1  one-cycle interrupt pulse
IRQ_STATUS  out  32  latched with irq_o; see below
SAMPLES  out  32  words written to the buffer just closed; latched with irq_o

Behaviour:
- Reset: all outputs 0; FIFO empty; address queue empty; state IDLE. dma_fifo_reset_i applies the same clear synchronously. The clear also drops any burst in flight; mem_valid_o is low the next cycle.
- FIFO write: a word is pushed when pcap_dat_valid_i is high. If the FIFO is full, the word is dropped and the sticky overflow flag sets; the flag clears only on reset or dma_fifo_reset_i.
- dma_full_o is registered and asserts when count >= depth-FULL_MARGIN.
- Address queue is one entry deep. DMA_ADDR_WSTB loads it. A strobe while the entry is already valid overwrites it.
- FSM states:
  - IDLE: wait for a valid queued address, then load base, clear offset, go to WAIT.
  - WAIT: go to BURST if count >= BURST_LEN. Go to BURST with the remaining count if a done is pending and count > 0. Go to CLOSE if a done is pending and count = 0.
  - BURST: beat n transfers on mem_valid_o & mem_ready_i. mem_valid_o must stay high and the beat stable until accepted. mem_addr_o = base+offset; offset increases by 4 per accepted beat. mem_last_o is high on the final beat. Data comes from the FIFO head with zero added latency (first-word-fall-through). After the last beat:
    - offset == BLOCK_SIZE: go to CLOSE.
    - done pending and FIFO empty: go to CLOSE.
    - otherwise: go to WAIT.
  - CLOSE: pulse irq_o; latch IRQ_STATUS and SAMPLES = offset/4. If a queued address is valid, consume it as the new base and go to WAIT; otherwise go to IDLE.
- Blocking: while in IDLE with no address, data accumulates in the FIFO (stall, no drop until full). The stall sets status bit 3 on the next irq.
- IRQ_STATUS bits:
  - bit0 block full
  - bit1 capture done
  - bit2 overflow
  - bit3 address stall occurred
  - bit4 timeout flush
  - others 0
  Sticky bits 2 and 3 are reported on every irq after they set.
- pcap_done_i sets a done-pending latch. The latch clears in CLOSE. A done pulse arriving mid-burst is kept and applied afterwards.
- Simultaneous FIFO push and pop: count is unchanged.

Optional Feature:
PCAP_DMA_TIMEOUT_EN:
- Defined: a counter of clocks in WAIT with 0 < count < BURST_LEN and no new push. When it reaches TIMEOUT (TIMEOUT != 0), issue a short burst of count beats. After that burst, go to CLOSE with bit4 set, regardless of offset.
- Undefined: the TIMEOUT port is present but ignored, and partial data is flushed only by done or a full block.

Decomposition:
- Shared package pcap_dma_pkg: state enum (IDLE, WAIT, BURST, CLOSE), IRQ_STATUS bit-index constants, and the beat byte stride (4).
- Sub-module pcap_dma_fifo: synchronous FWFT FIFO providing count, full, and synchronous clear.

Test Plan:
- BLOCK_SIZE=256, DMA_ADDR=0x1000 strobed, 64 contiguous valid words 0..63 -> 4 bursts at 0x1000/0x1040/0x1080/0x10C0, mem_last_o on beats 15/31/47/63, irq_o with IRQ_STATUS=0x1, SAMPLES=64.
- 5 words then pcap_done_i -> one 5-beat burst with mem_last_o on beat 5, then irq with IRQ_STATUS=0x2, SAMPLES=5.
- No DMA_ADDR, push 260 words (depth 256) -> dma_full_o high at count 252, last 4 words dropped; after an address strobe, the next irq has bits 2 and 3 set.
- mem_ready_i toggled 1/0 every cycle during a burst -> each beat held stable while not accepted, addresses strictly +4, no duplicated or lost words.
- dma_fifo_reset_i asserted mid-burst -> mem_valid_o low the next cycle, count 0, state IDLE, overflow flag cleared.
- With PCAP_DMA_TIMEOUT_EN and TIMEOUT=100, push 3 words and go idle -> a 3-beat burst starts 100 clocks after the last push, then irq with bit4 set and SAMPLES=3.
